mem_row_fetcher: RTL and testbench
==================================

// Module: mem_row_fetcher
// PURPOSE
// - Read-only master on the memory req/ack bus. Fetches a strided run of DATA_WIDTH words
//   (one matrix row/column) from memory and buffers them for the multiplier datapath.
// - Sits directly upstream of the memory slave. Takes one command; emits a valid/ready word stream.
// PARAMETERS
// DATA_WIDTH  256  width of one memory word / output word
// ADDR_WIDTH  16   memory word-address width
// CNT_WIDTH   8    width of word-count field
// FIFO_DEPTH  4    output buffer depth, power of 2, >=2
// PORTS
// clk         in   1           clock, rising edge
// reset       in   1           asynchronous, active-high reset
// cmd_valid   in   1           command offered
// cmd_ready   out  1           fetcher idle, command accepted when valid&ready
// cmd_base    in   ADDR_WIDTH  first word address
// cmd_stride  in   ADDR_WIDTH  address increment between words
// cmd_count   in   CNT_WIDTH   number of words to fetch (0 allowed)
// mem_req     out  1           memory request
// mem_ack     in   1           memory acknowledge (1-cycle pulse)
// mem_w_en    out  1           tied 0; this block never writes
// mem_addr    out  ADDR_WIDTH  request address, stable while mem_req=1
// mem_data    in   DATA_WIDTH  read data, valid in the cycle mem_ack=1
// out_valid   out  1           out_data valid
// out_ready   in   1           consumer accepts word
// out_data    out  DATA_WIDTH  fetched word, FIFO head
// out_last    out  1           marks final word of the command
// done        out  1           1-cycle pulse when last word is written into the FIFO
// protocol_err out 1           sticky; set on mem_ack while mem_req=0
// BEHAVIOUR
// - Reset: all outputs 0 except cmd_ready=1. FSM=IDLE. FIFO empty. Counters cleared. protocol_err cleared.
//   Reset mid-command aborts the command. No further mem_req. Buffered words are discarded.
// - FSM states: IDLE, WAIT, REQ, GAP.
//   IDLE: cmd_ready=1. On accept, latch base/stride/count and set addr=base.
//     count==0 -> done pulses next cycle, stay IDLE, issue no request.
//     count>0  -> go to WAIT.
//   WAIT: when FIFO free slots > 0, next cycle enter REQ with mem_req=1 (mem_req is registered).
//   REQ: hold mem_req=1 and mem_addr until mem_ack is sampled high.
//     On ack, push mem_data into the FIFO, tagging last=(remaining==1), then drop mem_req.
//     On the final word: pulse done and go to IDLE. Otherwise addr+=stride and go to GAP.
//   GAP: mem_req=0 for exactly 1 cycle (req-ack protocol minimum), then go to WAIT.
// - One outstanding request at most. Earliest timing: accept at T, mem_req rises at T+1,
//   ack at T+2, out_valid at T+3. Max throughput is 1 word per 3 cycles.
// - Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently. stride=0 re-reads one address.
// - Backpressure: no request is raised while the FIFO is full. Words are never dropped.
//   The FIFO is written on ack and read on out_valid&out_ready. Simultaneous push and pop
//   on a full FIFO is legal: occupancy is unchanged.
// - mem_ack with mem_req=0: ignored for data, sets protocol_err. mem_ack on the same cycle
//   mem_req rises cannot happen, because req is registered and the slave samples it.
// - cmd_valid while busy: ignored (cmd_ready=0). A new command is accepted in the cycle
//   after done. out_last/words of the previous command may still be draining; the FIFO
//   preserves order.
// STRUCTURE
// - Shared package mm_pkg: typedef enum logic[1:0] fetch_state_t {IDLE,WAIT,REQ,GAP}.
//   Also default width localparams DATA_WIDTH/ADDR_WIDTH, reused by the memory slave.
// - Sub-module mm_sync_fifo (WIDTH=DATA_WIDTH+1, DEPTH=FIFO_DEPTH). Registered output,
//   full/empty/count. The last bit is stored alongside the data.
// - Top level: FSM, address register, remaining counter, protocol_err flag.
// TESTING
// - base=0x0010, stride=2, count=4, slave acks 1 cycle after req, out_ready=1
//   -> mem_addr 0x10,0x12,0x14,0x16; 4 words in order; out_last on 4th; done once; mem_w_en=0 throughout.
// - count=0 -> done pulses at T+1; mem_req never rises; cmd_ready back to 1 at T+1.
// - FIFO_DEPTH=4, count=8, out_ready=0 -> exactly 4 acks, then mem_req stays 0.
//   Release out_ready -> remaining 4 words fetched with no data loss.
// - base=0xFFFE, stride=1, count=3 -> mem_addr 0xFFFE, 0xFFFF, 0x0000.
// - reset asserted mid-REQ (between 2nd and 3rd word) -> mem_req=0, out_valid=0,
//   cmd_ready=1 immediately; no done pulse.
// - slave pulses mem_ack while idle -> protocol_err=1 and stays 1; FIFO unchanged; clears only on reset.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and default widths for the matrix-multiply memory path.
// Used by the row fetcher and the memory slave.
package mm_pkg;

    localparam int DATA_WIDTH = 256;
    localparam int ADDR_WIDTH = 16;
    localparam int CNT_WIDTH  = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REQ,
        GAP
    } fetch_state_t;

endpackage

// File: rtl/mm_sync_fifo.sv
// Single-clock FIFO with full/empty/count flags.
// Head entry is read straight from the storage registers.
module mm_sync_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_MAX);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rptr];
    assign do_pop  = pop && !empty;
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_ONE;
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/mem_row_fetcher.sv
// Read-only memory master: fetches a strided run of words for one command
// and streams them out through a small buffer with a last-word tag.
module mem_row_fetcher #(
    parameter int DATA_WIDTH = mm_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mm_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH  = mm_pkg::CNT_WIDTH,
    parameter int FIFO_DEPTH = mm_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_stride,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    output logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done,
    output logic                  protocol_err
);

    import mm_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]        CNT_FULL = FIFO_DEPTH[CW-1:0];
    localparam logic [CNT_WIDTH-1:0] REM_ONE  = 1;

    fetch_state_t          state;
    fetch_state_t          state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] stride;
    logic [CNT_WIDTH-1:0]  remaining;
    logic                  done_q;
    logic                  perr_q;

    logic                  accept;
    logic                  ack_ok;
    logic                  last_word;
    logic                  has_space;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH:0]   fifo_wdata;
    logic [DATA_WIDTH:0]   fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_cnt;

    assign cmd_ready    = (state == IDLE);
    assign mem_req      = (state == REQ);
    assign mem_w_en     = 1'b0;
    assign mem_addr     = addr;
    assign done         = done_q;
    assign protocol_err = perr_q;

    assign accept    = cmd_valid && cmd_ready;
    assign ack_ok    = mem_ack && mem_req;
    assign last_word = (remaining == REM_ONE);
    // Only this block fills the buffer, so space seen before a request
    // is still there when its ack returns.
    assign has_space = (fifo_cnt != CNT_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && cmd_count != '0) begin
                    state_nx = has_space ? REQ : WAIT;
                end
            end
            WAIT: begin
                if (has_space) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nx = last_word ? IDLE : GAP;
                end
            end
            GAP: begin
                state_nx = has_space ? REQ : WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            stride    <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            done_q <= (accept && cmd_count == '0) || (ack_ok && last_word);
            if (mem_ack && !mem_req) begin
                perr_q <= 1'b1;
            end
            if (accept) begin
                addr      <= cmd_base;
                stride    <= cmd_stride;
                remaining <= cmd_count;
            end else if (ack_ok) begin
                remaining <= remaining - REM_ONE;
                if (!last_word) begin
                    addr <= addr + stride;
                end
            end
        end
    end

    assign fifo_push  = ack_ok && !fifo_full;
    assign fifo_pop   = out_valid && out_ready;
    assign fifo_wdata = {last_word, mem_data};

    mm_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
    assign out_last  = !fifo_empty && fifo_rdata[DATA_WIDTH];

endmodule

// File: tb/tb_mem_row_fetcher.sv
// Directed bench for mem_row_fetcher with a one-cycle-ack memory slave.
// Words carry their own address so order and loss are visible.
module tb_mem_row_fetcher;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [15:0]  cmd_base = '0;
    logic [15:0]  cmd_stride = '0;
    logic [7:0]   cmd_count = '0;
    logic         mem_req;
    logic         mem_ack;
    logic         mem_w_en;
    logic [15:0]  mem_addr;
    logic [255:0] mem_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] out_data;
    logic         out_last;
    logic         done;
    logic         protocol_err;

    logic         ack_s;
    logic         ack_spur = 1'b0;

    int           checks = 0;
    int           failures = 0;

    logic [15:0]  ackq[$];
    logic [255:0] outq[$];
    logic         lastq[$];
    int           dcount = 0;
    int           wen_bad = 0;

    always #5 clk = ~clk;

    assign mem_ack = ack_s | ack_spur;

    mem_row_fetcher dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_base     (cmd_base),
        .cmd_stride   (cmd_stride),
        .cmd_count    (cmd_count),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_w_en     (mem_w_en),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .done         (done),
        .protocol_err (protocol_err)
    );

    function automatic logic [255:0] word(input logic [15:0] a);
        return {16{a}};
    endfunction

    // Slave: acks one cycle after it sees a request, one pulse per request.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_s    <= 1'b0;
            mem_data <= '0;
        end else begin
            ack_s    <= mem_req && !ack_s;
            mem_data <= word(mem_addr);
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (mem_ack && mem_req) ackq.push_back(mem_addr);
            if (out_valid && out_ready) begin
                outq.push_back(out_data);
                lastq.push_back(out_last);
            end
            if (done) dcount++;
            if (mem_w_en) wen_bad++;
        end
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        ackq.delete();
        outq.delete();
        lastq.delete();
    endtask

    task automatic issue(input logic [15:0] b, input logic [15:0] s,
                         input logic [7:0] n);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_base   = b;
        cmd_stride = s;
        cmd_count  = n;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget, input string tag);
        int n = 0;
        while (dcount == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 256'(dcount > start), 256'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int d0;

    initial begin
        idle(3);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_perr", protocol_err, 0);
        @(negedge clk) reset = 1'b0;
        idle(2);

        // Strided fetch, consumer always ready
        clear_logs();
        out_ready = 1'b1;
        d0 = dcount;
        issue(16'h0010, 16'd2, 8'd4);
        @(negedge clk);
        check("lat_req", mem_req, 1);
        check("lat_addr", mem_addr, 16'h0010);
        check("lat_busy", cmd_ready, 0);
        wait_done(d0, 50, "t1_done_to");
        idle(5);
        check("t1_dcount", dcount - d0, 1);
        check("t1_nacks", ackq.size(), 4);
        check("t1_nout", outq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", ackq[i], 16'h0010 + 16'(2 * i));
            check("t1_data", outq[i], word(16'h0010 + 16'(2 * i)));
            check("t1_last", lastq[i], (i == 3) ? 1'b1 : 1'b0);
        end

        // Zero-length command
        clear_logs();
        d0 = dcount;
        issue(16'h1234, 16'd1, 8'd0);
        @(negedge clk);
        check("z_done", done, 1);
        check("z_ready", cmd_ready, 1);
        check("z_req", mem_req, 0);
        @(negedge clk);
        check("z_done_off", done, 0);
        idle(3);
        check("z_nacks", ackq.size(), 0);
        check("z_dcount", dcount - d0, 1);

        // Backpressure: buffer fills, then drains with no loss
        clear_logs();
        out_ready = 1'b0;
        d0 = dcount;
        issue(16'h0100, 16'd1, 8'd8);
        idle(60);
        check("bp_nacks", ackq.size(), 4);
        check("bp_req", mem_req, 0);
        check("bp_valid", out_valid, 1);
        check("bp_nodone", dcount - d0, 0);
        out_ready = 1'b1;
        wait_done(d0, 100, "bp_done_to");
        idle(6);
        check("bp_nout", outq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("bp_data", outq[i], word(16'h0100 + 16'(i)));
            check("bp_last", lastq[i], (i == 7) ? 1'b1 : 1'b0);
        end

        // Address wrap
        clear_logs();
        d0 = dcount;
        issue(16'hFFFE, 16'd1, 8'd3);
        wait_done(d0, 50, "wr_done_to");
        idle(5);
        check("wr_nacks", ackq.size(), 3);
        check("wr_a0", ackq[0], 16'hFFFE);
        check("wr_a1", ackq[1], 16'hFFFF);
        check("wr_a2", ackq[2], 16'h0000);
        check("wr_d2", outq[2], word(16'h0000));

        // Reset during the third request
        clear_logs();
        d0 = dcount;
        issue(16'h0200, 16'd4, 8'd4);
        begin
            int n = 0;
            while (!(ackq.size() == 2 && mem_req) && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("rs_reach", 256'(ackq.size() == 2 && mem_req), 256'd1);
        end
        reset = 1'b1;
        #1;
        check("rs_req", mem_req, 0);
        check("rs_valid", out_valid, 0);
        check("rs_ready", cmd_ready, 1);
        @(negedge clk) reset = 1'b0;
        idle(10);
        check("rs_nodone", dcount - d0, 0);
        check("rs_req_after", mem_req, 0);
        check("rs_nacks", ackq.size(), 2);

        // Spurious ack while idle
        check("pe_clear", protocol_err, 0);
        @(negedge clk) ack_spur = 1'b1;
        @(negedge clk) ack_spur = 1'b0;
        check("pe_set", protocol_err, 1);
        check("pe_fifo", out_valid, 0);
        idle(5);
        check("pe_sticky", protocol_err, 1);
        reset = 1'b1;
        #1;
        check("pe_reset", protocol_err, 0);
        @(negedge clk) reset = 1'b0;

        check("wen_never", wen_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
